// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, shift, flag and FSM encodings for dp_alu
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_e;

  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CPSR, S_RD_RN, S_RD_RM, S_RD_RS, S_EXEC, S_WB
  } state_e;

  // TST/TEQ/CMP/CMN occupy 8..B
  function automatic logic is_test_op(input opcode_e op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic skips_rn(input opcode_e op);
    return (op == OP_MOV) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - operand2 shifter with ARM amount-zero and over-range rules
module barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       amount,
  input  logic             amount_is_reg,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [7:0] W8 = 8'(WIDTH);

  logic             msb;
  logic [WIDTH:0]   lsl_x;
  logic [WIDTH:0]   lsr_x;
  logic [WIDTH:0]   asr_x;
  logic [WIDTH-1:0] ror_x;
  logic [LW-1:0]    rot;

  always_comb begin
    msb   = value[WIDTH-1];
    // one extra bit on the shifted-out side carries the last bit lost
    lsl_x = {1'b0, value} << amount;
    lsr_x = {value, 1'b0} >> amount;
    asr_x = $signed({value, 1'b0}) >>> amount;
    rot   = amount[LW-1:0];
    ror_x = WIDTH'({value, value} >> rot);
    result = value;
    c_out  = c_in;
    if (amount == 8'd0) begin
      if (!amount_is_reg) begin
        case (shift_type)
          SH_LSR: begin result = '0; c_out = msb; end
          SH_ASR: begin result = {WIDTH{msb}}; c_out = msb; end
          SH_ROR: begin result = {c_in, value[WIDTH-1:1]}; c_out = value[0]; end
          default: begin result = value; c_out = c_in; end
        endcase
      end
    end else begin
      case (shift_type)
        SH_LSL: begin
          if (amount < W8) {c_out, result} = lsl_x;
          else if (amount == W8) begin result = '0; c_out = value[0]; end
          else begin result = '0; c_out = 1'b0; end
        end
        SH_LSR: begin
          if (amount < W8) {result, c_out} = lsr_x;
          else if (amount == W8) begin result = '0; c_out = msb; end
          else begin result = '0; c_out = 1'b0; end
        end
        SH_ASR: begin
          if (amount < W8) {result, c_out} = asr_x;
          else begin result = {WIDTH{msb}}; c_out = msb; end
        end
        default: begin
          result = ror_x;
          c_out  = ror_x[WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/dp_alu.sv
// rtl/dp_alu.sv - multi-cycle ARM data-processing unit with register/CPSR access FSM
module dp_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             immediate,
  input  logic             s,
  input  logic [3:0]       opcode,
  input  logic [RBITS-1:0] rn,
  input  logic [RBITS-1:0] rd,
  input  logic [11:0]      operand2,
  output logic             read_en,
  output logic [RBITS-1:0] read_reg,
  input  logic [WIDTH-1:0] read_value,
  output logic             write_en,
  output logic [RBITS-1:0] write_reg,
  output logic [WIDTH-1:0] write_value,
  output logic             write_restore_from_SPSR,
  output logic             cpsr_read_en,
  input  logic [31:0]      cpsr_read_value,
  output logic             cpsr_write_en,
  output logic [31:0]      cpsr_write_value,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d, after_rn;
  logic             phase_q;
  opcode_e          op_q;
  logic             imm_q, s_q;
  logic [RBITS-1:0] rn_q, rd_q;
  logic [11:0]      op2_q;
  logic [31:0]      cpsr_q;
  logic [WIDTH-1:0] rn_val_q, rm_val_q;
  logic [7:0]       rs_amt_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       nzcv_q;

  logic             is_rd, is_test, pc_dest, c_in;
  logic             unused_nz;
  logic [WIDTH-1:0] sh_value, sh_out;
  logic [1:0]       sh_type;
  logic [7:0]       sh_amount;
  logic             sh_amount_is_reg, sh_c;
  logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
  logic             add_c, arith;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_nzcv;

  assign is_rd     = (state_q == S_RD_CPSR) || (state_q == S_RD_RN) ||
                     (state_q == S_RD_RM) || (state_q == S_RD_RS);
  assign is_test   = is_test_op(op_q);
  assign pc_dest   = (rd_q == '1);
  assign c_in      = cpsr_q[FLAG_C];
  assign unused_nz = &cpsr_q[FLAG_N:FLAG_Z];

  always_comb begin
    after_rn = imm_q ? S_EXEC : S_RD_RM;
    state_d  = state_q;
    case (state_q)
      S_IDLE:    if (en) state_d = S_RD_CPSR;
      S_RD_CPSR: if (phase_q) state_d = skips_rn(op_q) ? after_rn : S_RD_RN;
      S_RD_RN:   if (phase_q) state_d = after_rn;
      S_RD_RM:   if (phase_q) state_d = op2_q[4] ? S_RD_RS : S_EXEC;
      S_RD_RS:   if (phase_q) state_d = S_EXEC;
      S_EXEC:    state_d = S_WB;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      op_q     <= OP_AND;
      imm_q    <= 1'b0;
      s_q      <= 1'b0;
      rn_q     <= '0;
      rd_q     <= '0;
      op2_q    <= '0;
      cpsr_q   <= '0;
      rn_val_q <= '0;
      rm_val_q <= '0;
      rs_amt_q <= '0;
      res_q    <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= is_rd && !phase_q;
      if (state_q == S_IDLE && en) begin
        op_q  <= opcode_e'(opcode);
        imm_q <= immediate;
        s_q   <= s;
        rn_q  <= rn;
        rd_q  <= rd;
        op2_q <= operand2;
      end
      // second cycle of each read state captures the returned value
      if (phase_q) begin
        case (state_q)
          S_RD_CPSR: cpsr_q   <= cpsr_read_value;
          S_RD_RN:   rn_val_q <= read_value;
          S_RD_RM:   rm_val_q <= read_value;
          S_RD_RS:   rs_amt_q <= read_value[7:0];
          default:   ;
        endcase
      end
      if (state_q == S_EXEC) begin
        res_q  <= alu_res;
        nzcv_q <= alu_nzcv;
      end
    end
  end

  always_comb begin
    sh_value         = imm_q ? WIDTH'(op2_q[7:0]) : rm_val_q;
    sh_type          = imm_q ? SH_ROR : op2_q[6:5];
    sh_amount        = imm_q ? {3'b000, op2_q[11:8], 1'b0}
                             : (op2_q[4] ? rs_amt_q : {3'b000, op2_q[11:7]});
    sh_amount_is_reg = imm_q || op2_q[4];
  end

  barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value         (sh_value),
    .shift_type    (sh_type),
    .amount        (sh_amount),
    .amount_is_reg (sh_amount_is_reg),
    .c_in          (c_in),
    .result        (sh_out),
    .c_out         (sh_c)
  );

  always_comb begin
    add_x     = rn_val_q;
    add_y     = sh_out;
    add_c     = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    // subtraction is x + ~y + carry, so C comes out as NOT borrow
    case (op_q)
      OP_SUB, OP_CMP: begin add_y = ~sh_out; add_c = 1'b1; end
      OP_RSB:         begin add_x = sh_out; add_y = ~rn_val_q; add_c = 1'b1; end
      OP_ADC:         add_c = c_in;
      OP_SBC:         begin add_y = ~sh_out; add_c = c_in; end
      OP_RSC:         begin add_x = sh_out; add_y = ~rn_val_q; add_c = c_in; end
      OP_AND, OP_TST: begin arith = 1'b0; logic_res = rn_val_q & sh_out; end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = rn_val_q ^ sh_out; end
      OP_ORR:         begin arith = 1'b0; logic_res = rn_val_q | sh_out; end
      OP_MOV:         begin arith = 1'b0; logic_res = sh_out; end
      OP_BIC:         begin arith = 1'b0; logic_res = rn_val_q & ~sh_out; end
      OP_MVN:         begin arith = 1'b0; logic_res = ~sh_out; end
      default:        ;
    endcase
    sum     = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_c);
    alu_res = arith ? sum[WIDTH-1:0] : logic_res;
    alu_nzcv[3] = alu_res[WIDTH-1];
    alu_nzcv[2] = (alu_res == '0);
    alu_nzcv[1] = arith ? sum[WIDTH] : sh_c;
    alu_nzcv[0] = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                           (sum[WIDTH-1] != add_x[WIDTH-1]))
                        : cpsr_q[FLAG_V];
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_WB);
    cpsr_read_en = (state_q == S_RD_CPSR) && !phase_q;
    read_en      = ((state_q == S_RD_RN) || (state_q == S_RD_RM) ||
                    (state_q == S_RD_RS)) && !phase_q;
    read_reg     = '0;
    if (read_en) begin
      case (state_q)
        S_RD_RN: read_reg = rn_q;
        S_RD_RM: read_reg = RBITS'(op2_q[3:0]);
        default: read_reg = RBITS'(op2_q[11:8]);
      endcase
    end
    write_en                = done && !is_test;
    write_reg               = write_en ? rd_q : '0;
    write_value             = write_en ? res_q : '0;
    write_restore_from_SPSR = write_en && s_q && pc_dest;
    cpsr_write_en           = done && (is_test || (s_q && !pc_dest));
    cpsr_write_value        = cpsr_write_en ? {nzcv_q, cpsr_q[27:0]} : '0;
  end

endmodule

// File: tb/tb_dp_alu.sv
// tb/tb_dp_alu.sv - scoreboard bench for dp_alu at WIDTH 32 and 16
module tb_dp_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, en_h = 1'b0, immediate = 1'b0, s = 1'b0;
  logic [3:0]  opcode = '0, rn = '0, rd = '0;
  logic [11:0] operand2 = '0;

  logic        read_en, write_en, write_restore, cpsr_read_en, cpsr_write_en, busy, done;
  logic [3:0]  read_reg, write_reg;
  logic [31:0] read_value = '0, write_value, cpsr_read_value = '0, cpsr_write_value;

  logic        read_en_h, write_en_h, write_restore_h, cpsr_read_en_h, cpsr_write_en_h, busy_h, done_h;
  logic [3:0]  read_reg_h, write_reg_h;
  logic [15:0] read_value_h = '0, write_value_h;
  logic [31:0] cpsr_read_value_h = '0, cpsr_write_value_h;

  dp_alu #(.WIDTH(32), .RBITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .immediate(immediate), .s(s), .opcode(opcode),
    .rn(rn), .rd(rd), .operand2(operand2),
    .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
    .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
    .write_restore_from_SPSR(write_restore),
    .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
    .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
    .busy(busy), .done(done)
  );

  dp_alu #(.WIDTH(16), .RBITS(4)) dut_h (
    .clk(clk), .rst(rst), .en(en_h), .immediate(immediate), .s(s), .opcode(opcode),
    .rn(rn), .rd(rd), .operand2(operand2),
    .read_en(read_en_h), .read_reg(read_reg_h), .read_value(read_value_h),
    .write_en(write_en_h), .write_reg(write_reg_h), .write_value(write_value_h),
    .write_restore_from_SPSR(write_restore_h),
    .cpsr_read_en(cpsr_read_en_h), .cpsr_read_value(cpsr_read_value_h),
    .cpsr_write_en(cpsr_write_en_h), .cpsr_write_value(cpsr_write_value_h),
    .busy(busy_h), .done(done_h)
  );

  // register file and CPSR models answering the DUT's read/write strobes
  logic [31:0] regs [16] = '{32'd0, 32'd5, 32'd7, 32'd0, 32'd20, 32'd3, 32'h80000001, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] cpsr = 32'h000000D3;
  logic [15:0] regs_h [16] = '{16'd0, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                               16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

  always @(posedge clk) begin
    if (read_en) read_value <= regs[read_reg];
    if (cpsr_read_en) cpsr_read_value <= cpsr;
    if (write_en) regs[write_reg] <= write_value;
    if (cpsr_write_en) cpsr <= cpsr_write_value;
    if (read_en_h) read_value_h <= regs_h[read_reg_h];
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  rg;
    logic [31:0] val;
    logic        rs;
    logic        cw;
    logic [3:0]  nzcv;
    int          lat;
    time         t0;
  } exp_t;
  exp_t sbq[$];

  function automatic exp_t mk(input string nm, input logic wr, input logic [3:0] rg,
                              input logic [31:0] val, input logic rs, input logic cw,
                              input logic [3:0] nzcv, input int lat);
    exp_t e;
    e.name = nm; e.wr = wr; e.rg = rg; e.val = val; e.rs = rs;
    e.cw = cw; e.nzcv = nzcv; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic im, input logic ss, input logic [3:0] n,
                       input logic [3:0] d, input logic [11:0] o2, input logic push, input exp_t e);
    @(negedge clk);
    opcode = op; immediate = im; s = ss; rn = n; rd = d; operand2 = o2; en = 1'b1;
    @(posedge clk);
    e.t0 = $time;
    if (push) sbq.push_back(e);
    #1 en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sbq.size(), 0);
    @(negedge clk);
  endtask

  // scoreboard: every done pops one expected writeback
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst === 1'b0) begin
      if (done) begin
        tests++;
        assert (sbq.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_done: observed done=1 expected no pending instruction");
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          lat = int'(($time - e.t0 - 5) / 10) + 1;
          check({e.name, ".write_en"}, write_en, e.wr);
          if (e.wr) begin
            check({e.name, ".write_reg"}, write_reg, e.rg);
            check({e.name, ".write_value"}, write_value, e.val);
          end
          check({e.name, ".restore"}, write_restore, e.rs);
          check({e.name, ".cpsr_write_en"}, cpsr_write_en, e.cw);
          if (e.cw) check({e.name, ".cpsr_write_value"}, cpsr_write_value, {e.nzcv, 28'h00000D3});
          check({e.name, ".latency"}, lat, e.lat);
        end
      end else begin
        check("write_outside_done", {write_en, cpsr_write_en}, 2'b00);
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, read_en, read_reg, write_en, write_reg, write_restore,
                            cpsr_read_en, cpsr_write_en}, 0);
    check("reset_values", {write_value, cpsr_write_value}, 0);
    rst = 1'b0;

    issue(4'h4, 0, 1, 4'd1, 4'd0, 12'h002, 1, mk("adds_r0", 1, 4'd0, 32'd12, 0, 1, 4'b0000, 8));
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    drain();
    issue(4'h2, 0, 1, 4'd5, 4'd3, 12'h004, 1, mk("subs_r3", 1, 4'd3, 32'hFFFFFFEF, 0, 1, 4'b1000, 8));
    drain();
    issue(4'hD, 1, 1, 4'd0, 4'd9, 12'h4FF, 1, mk("movs_imm", 1, 4'd9, 32'hFF000000, 0, 1, 4'b1010, 4));
    drain();
    issue(4'hD, 0, 1, 4'd0, 4'd10, 12'h026, 1, mk("movs_lsr0", 1, 4'd10, 32'd0, 0, 1, 4'b0110, 6));
    drain();
    issue(4'h4, 0, 1, 4'd1, 4'd11, 12'h002, 1, mk("adds_clrc", 1, 4'd11, 32'd12, 0, 1, 4'b0000, 8));
    drain();
    issue(4'hD, 0, 1, 4'd0, 4'd12, 12'h066, 1, mk("movs_rrx", 1, 4'd12, 32'h40000000, 0, 1, 4'b0010, 6));
    drain();
    issue(4'h4, 0, 1, 4'd1, 4'd14, 12'h112, 1, mk("adds_lsl_rs", 1, 4'd14, 32'd229, 0, 1, 4'b0000, 10));
    drain();
    issue(4'hA, 0, 0, 4'd4, 4'd0, 12'h004, 1, mk("cmp_eq", 0, 4'd0, 32'd0, 0, 1, 4'b0110, 8));
    drain();
    issue(4'h5, 0, 1, 4'd1, 4'd15, 12'h002, 1, mk("adcs_pc", 1, 4'd15, 32'd13, 1, 0, 4'b0000, 8));
    drain();

    issue(4'h4, 0, 0, 4'd1, 4'd13, 12'h002, 1, mk("add_busy_en", 1, 4'd13, 32'd12, 0, 0, 4'b0000, 8));
    @(negedge clk); @(negedge clk);
    opcode = 4'hD; immediate = 1'b1; s = 1'b0; rd = 4'd8; operand2 = 12'h001; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    check("ignored_en_r8", regs[8], 32'd0);

    issue(4'h4, 0, 1, 4'd1, 4'd7, 12'h002, 0, mk("rst_victim", 1, 4'd7, 32'd12, 0, 1, 4'b0000, 8));
    repeat (5) @(negedge clk);
    check("rd_rm_request", {read_en, read_reg}, {1'b1, 4'd2});
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_rst", busy, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_write_r7", regs[7], 32'd0);
    check("rst_no_cpsr_write", cpsr, {4'b0110, 28'h00000D3});

    opcode = 4'h4; immediate = 1'b0; s = 1'b1; rn = 4'd1; rd = 4'd7; operand2 = 12'h002;
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    check("rst_over_en_busy", busy, 0);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("rst_over_en_idle", busy, 0);

    opcode = 4'h4; immediate = 1'b0; s = 1'b1; rn = 4'd1; rd = 4'd0; operand2 = 12'h002;
    en_h = 1'b1;
    @(posedge clk);
    #1 en_h = 1'b0;
    n = 0;
    while (!done_h && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("w16_done", done_h, 1);
    check("w16_latency", n, 8);
    check("w16_write", {write_en_h, write_reg_h, write_value_h}, {1'b1, 4'd0, 16'h0000});
    check("w16_cpsr_en", cpsr_write_en_h, 1);
    check("w16_nzcv", cpsr_write_value_h[31:28], 4'b0110);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dp_alu.md
DP_ALU -- requirements
Module: dp_alu

Interface
REQ-001 Parameter WIDTH, default 32, meaning datapath width; legal values 16, 32, 64.
REQ-002 Parameter RBITS, default 4, meaning register index width.
REQ-003 Port clk, input, 1 bit: the only clock; all logic changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports en/immediate/s (in, 1 each), opcode (in, 4), rn/rd (in, RBITS), operand2 (in, 12): instruction fields, sampled only when en=1 in IDLE.
REQ-006 Ports read_en (out, 1), read_reg (out, RBITS), read_value (in, WIDTH): register read; value valid the cycle after read_en.
REQ-007 Ports write_en (out, 1), write_reg (out, RBITS), write_value (out, WIDTH), write_restore_from_SPSR (out, 1): register write.
REQ-008 Ports cpsr_read_en (out, 1), cpsr_read_value (in, 32), cpsr_write_en (out, 1), cpsr_write_value (out, 32): status access; N/Z/C/V in bits 31/30/29/28.
REQ-009 Ports busy (out, 1), done (out, 1): busy high from the cycle after accept until the cycle after done; done is a one-cycle pulse.

Function
REQ-010 FSM states: IDLE, RD_CPSR, RD_RN, RD_RM, RD_RS, EXEC, WB; every RD_* state is 2 cycles (request cycle, capture cycle).
REQ-011 Order: RD_CPSR, RD_RN (skipped for MOV/MVN), RD_RM (skipped if immediate), RD_RS (only if !immediate and operand2[4]=1), EXEC, WB, IDLE.
REQ-012 Latency: register-operand ADD has done in cycle 8 after the en-sampling edge; each skipped read subtracts 2, RD_RS adds 2.
REQ-013 en while busy is ignored; en is not queued.
REQ-014 Immediate operand: zero-extended operand2[7:0] rotated right by 2*operand2[11:8] mod WIDTH; shifter carry equals C_in when rotate=0, otherwise result bit WIDTH-1.
REQ-015 Register operand: Rm=operand2[3:0]; type operand2[6:5] = LSL/LSR/ASR/ROR; amount operand2[11:7] when bit4=0, else Rs[7:0] with Rs=operand2[11:8].
REQ-016 Immediate amount 0 encodes: LSL -> unshifted, C unchanged; LSR -> WIDTH (result 0, C=msb); ASR -> WIDTH (all sign, C=msb); ROR -> RRX ({C,Rm>>1}, C=Rm[0]).
REQ-017 Register amount 0 -> unshifted, C unchanged; LSL/LSR amount=WIDTH -> result 0, C=lsb/msb; amount>WIDTH -> result 0, C=0; ASR amount>=WIDTH -> all sign, C=msb; ROR uses amount mod WIDTH, C=msb of result when amount!=0.
REQ-018 All 16 ARM data-processing opcodes; ADC/SBC/RSC use C_in; SUB-type C = NOT borrow.
REQ-019 Arithmetic ops set C=carry out and V=signed overflow at WIDTH; logical ops set C=shifter carry and keep V.
REQ-020 N = result bit WIDTH-1; Z = (result==0).
REQ-021 TST/TEQ/CMP/CMN never write a register and always write flags, regardless of s.
REQ-022 Other ops write rd in WB; flags written in the same WB cycle only when s=1.
REQ-023 s=1 and rd=all-ones (PC): write_restore_from_SPSR=1 with write_en, cpsr_write_en stays 0.
REQ-024 cpsr_write_value keeps bits 27:0 of the CPSR value read in RD_CPSR.
REQ-025 All *_en outputs are high for exactly one cycle per access; done is asserted in WB.

Reset
REQ-026 rst=1 forces IDLE; on the next edge every output is 0 (busy, done, all *_en, regs, values).
REQ-027 rst mid-operation discards the instruction; no write or CPSR write is issued afterwards.
REQ-028 rst has priority over en in the same cycle.

Structure
REQ-029 Package alu_pkg: opcode codes, shift-type codes, flag bit positions, FSM state encoding.
REQ-030 Sub-module barrel_shifter: combinational, parametrised by WIDTH, returns the shifted value and the carry out; instantiated once.

Verification
REQ-031 r1=5, r2=7, ADDS r0,r1,r2 -> r0=12, NZCV=0000, done in cycle 8 after en.
REQ-032 r4=20, r5=3, SUBS r3,r5,r4 -> r3=0xFFFFFFEF, N=1 Z=0 C=0 V=0.
REQ-033 MOVS r9,#imm with operand2=0x4FF -> r9=0xFF000000, C=1; done in cycle 4 after en.
REQ-034 Rm=0x80000001, MOVS LSR #0 -> 0, Z=1, C=1; RRX with C=0 -> 0x40000000, C=1.
REQ-035 CMP 20,20 with s=0 -> Z=1 C=1, write_en never asserted; en pulse during busy -> no second done; rst in RD_RM -> no write, busy=0 next cycle.
REQ-036 WIDTH=16: ADDS 0xFFFF+1 -> 0, Z=1 C=1 V=0.
